// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundle of raster timing outputs produced by vga_timing_gen.
//   master : the timing generator (drives everything)
//   slave  : pixel/display pipeline consumers (read everything)
//   Signals:
//     hcount/vcount        current pixel column / line (CW bits)
//     hsync/vsync          sync outputs at the generator's configured polarity
//     hblank/vblank/de     blanking flags and data enable
//     line_start           1-cycle pulse when hcount becomes 0
//     frame_start          1-cycle pulse when (hcount,vcount) becomes (0,0)
//     frame_cnt            frames started since reset (only with VGA_TIMING_FRAME_CNT_EN)
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          de;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  modport master (
    output hcount, vcount, hsync, vsync, hblank, vblank, de, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblank, vblank, de, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator (one horizontal and one vertical
//   counter). All outputs are registered and describe the hcount/vcount
//   presented in the same cycle. A pixel enable lets a fast clock drive a
//   slower pixel rate.
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter.
//   Ports:
//     Clk    in   rising-edge clock
//     Rst_n  in   asynchronous active-low reset
//     En     in   pixel enable; raster advances one pixel per enabled cycle
//     vid    master modport of vga_timing_gen_if carrying all timing outputs
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            En,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int MAX_TOT  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_STA_C = CW'(HS_START);
  localparam logic [CW-1:0] HS_END_C = CW'(HS_END);
  localparam logic [CW-1:0] VS_STA_C = CW'(VS_START);
  localparam logic [CW-1:0] VS_END_C = CW'(VS_END);

  // Refuse to elaborate a mode the counters cannot represent.
  generate
    if ((H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
        ((longint'(1) << CW) < longint'(MAX_TOT))) begin : g_param_check
      $error("vga_timing_gen: zero timing parameter or CW too small for totals");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          running;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (En) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next counts first, then every flag is decoded from the next counts so the
  // registered flags line up with the registered counts. On the IDLE->RUN edge
  // the raster starts at (0,0) without incrementing.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (En) begin
          hcount_d      = '0;
          vcount_d      = '0;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        if (En) begin
          if (hcount_q == H_LAST) begin
            hcount_d     = '0;
            line_start_d = 1'b1;
            if (vcount_q == V_LAST) begin
              vcount_d      = '0;
              frame_start_d = 1'b1;
            end else begin
              vcount_d = vcount_q + CW'(1);
            end
          end else begin
            hcount_d = hcount_q + CW'(1);
          end
        end
      end
      default: ;
    endcase

    // Held counts in RUN decode to the same flags, so En=0 holds everything.
    running  = (state_d == RUN);
    hblank_d = !running || (hcount_d >= H_ACT_C);
    vblank_d = !running || (vcount_d >= V_ACT_C);
    de_d     = !hblank_d && !vblank_d;
    hsync_d  = (running && (hcount_d >= HS_STA_C) && (hcount_d < HS_END_C)) ? HS_POL : ~HS_POL;
    vsync_d  = (running && (vcount_d >= VS_STA_C) && (vcount_d < VS_END_C)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.hcount      = hcount_q;
  assign vid.vcount      = vcount_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.de          = de_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts on the same edge that raises frame_start, so frame 1 reads 1.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)             frame_cnt_q <= '0;
    else if (frame_start_d) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule
